// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    typedef enum logic [1:0] {
        LOCKWAIT = 2'd0,
        LOCKED   = 2'd1,
        APPLY    = 2'd2
    } fsm_state_t;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_DIV_W       = 8;
    localparam int DEF_DIV_VAL     = 10;
    localparam int DEF_PHASE_VAL   = 0;
    localparam int DEF_LOCK_CYCLES = 16;

    // Channel index width; a single channel still needs a 1-bit select.
    function automatic int CH_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: wrap counter, clamped phase, enable pulse and square wave.
// Latency: outputs are registered, one refclk after the counter value they decode.
// Backpressure: none; restart forces counter and outputs to zero on the next edge.
module clk_div_ch #(
    parameter int DIV_W = 8
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] phase,
    input  logic             restart,
    output logic             clk_en,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_m1;
    logic [DIV_W-1:0] p_eff;
    logic [DIV_W-1:0] rel;
    logic [DIV_W-1:0] half;
    logic             ch_on;

    // Phase clamp and phase-relative position; div=0 results are don't-care (gated below).
    always_comb begin
        ch_on  = (div != '0);
        div_m1 = div - DIV_W'(1);
        p_eff  = (phase > div_m1) ? div_m1 : phase;
        rel    = (cnt >= p_eff) ? (cnt - p_eff) : (cnt + div - p_eff);
        half   = div >> 1;
    end

    // Counter and registered outputs; a disabled channel sits at zero.
    always_ff @(posedge refclk) begin
        if (!reset || restart || !ch_on) begin
            cnt     <= '0;
            clk_en  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= (cnt >= div_m1) ? '0 : cnt + DIV_W'(1);
            clk_en  <= (cnt == p_eff);
            clk_out <= (rel < half);
        end
    end

endmodule

// File: rtl/multi_clk_div.sv
// Run-time reconfigurable N-channel clock divider with shadow config and lock qualifier.
// Latency: channel outputs 1 refclk after counter; commit takes 1 APPLY cycle, locked LOCK_CYCLES later.
// Backpressure: cfg_ready drops only during APPLY; writes stall there, commits there are ignored.
module multi_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEF_DIV     = DEF_DIV_VAL,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                          refclk,
    input  logic                          reset,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CH_IDX_W(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [DIV_W-1:0]              cfg_phase,
    input  logic                          cfg_commit,
    output logic [NUM_CH-1:0]             clk_en,
    output logic [NUM_CH-1:0]             clk_out,
    output logic                          locked
);

    localparam int               CH_W        = CH_IDX_W(NUM_CH);
    localparam int               LCNT_W      = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] DEF_DIV_V   = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] DEF_PHASE_V = DIV_W'(DEF_PHASE_VAL);

    fsm_state_t        state;
    fsm_state_t        next_state;
    logic [LCNT_W-1:0] lock_cnt;
    logic              wr_fire;
    logic              restart;

    logic [DIV_W-1:0]  sh_div    [NUM_CH];
    logic [DIV_W-1:0]  sh_phase  [NUM_CH];
    logic [DIV_W-1:0]  act_div   [NUM_CH];
    logic [DIV_W-1:0]  act_phase [NUM_CH];

    assign wr_fire = cfg_valid & cfg_ready;
    // Counters and outputs are held at zero on entry to and exit from APPLY.
    assign restart = (next_state == APPLY) || (state == APPLY);

    // Next-state and handshake/qualifier decode; commit wins over lock completion.
    always_comb begin
        next_state = state;
        cfg_ready  = 1'b1;
        locked     = 1'b0;
        case (state)
            LOCKWAIT: begin
                if (cfg_commit) begin
                    next_state = APPLY;
                end else if (lock_cnt == LCNT_W'(LOCK_CYCLES - 1)) begin
                    next_state = LOCKED;
                end
            end
            LOCKED: begin
                locked = 1'b1;
                if (cfg_commit) begin
                    next_state = APPLY;
                end
            end
            APPLY: begin
                cfg_ready  = 1'b0;
                next_state = LOCKWAIT;
            end
            default: next_state = LOCKWAIT;
        endcase
    end

    // State register.
    always_ff @(posedge refclk) begin
        if (!reset) begin
            state <= LOCKWAIT;
        end else begin
            state <= next_state;
        end
    end

    // Lock counter only runs in LOCKWAIT; cleared everywhere else so each entry starts at 0.
    always_ff @(posedge refclk) begin
        if (!reset || state != LOCKWAIT) begin
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + LCNT_W'(1);
        end
    end

    // Shadow bank: accepted writes land here; out-of-range channel indices match nothing.
    always_ff @(posedge refclk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_div[i]   <= DEF_DIV_V;
                sh_phase[i] <= DEF_PHASE_V;
            end
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    sh_div[i]   <= cfg_div;
                    sh_phase[i] <= cfg_phase;
                end
            end
        end
    end

    // Active bank loads at the end of APPLY, so a write accepted with the commit is included.
    always_ff @(posedge refclk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_div[i]   <= DEF_DIV_V;
                act_phase[i] <= DEF_PHASE_V;
            end
        end else if (state == APPLY) begin
            for (int i = 0; i < NUM_CH; i++) begin
                act_div[i]   <= sh_div[i];
                act_phase[i] <= sh_phase[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .refclk  (refclk),
            .reset   (reset),
            .div     (act_div[g]),
            .phase   (act_phase[g]),
            .restart (restart),
            .clk_en  (clk_en[g]),
            .clk_out (clk_out[g])
        );
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Scoreboard bench for multi_clk_div: arithmetic reference model feeds an expectation queue.
// Latency: one expectation per refclk edge, compared at the following falling edge.
// Backpressure: writes are held until the model says they were accepted (bounded retries).
module tb_multi_clk_div;

    localparam int NUM_CH      = 5;
    localparam int DIV_W       = 8;
    localparam int DEF_DIV     = 10;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = 3;

    logic              refclk     = 1'b0;
    logic              reset      = 1'b0;
    logic              cfg_valid  = 1'b0;
    logic              cfg_commit = 1'b0;
    logic [CH_W-1:0]   cfg_ch     = '0;
    logic [DIV_W-1:0]  cfg_div    = '0;
    logic [DIV_W-1:0]  cfg_phase  = '0;
    logic              cfg_ready;
    logic              locked;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] clk_out;

    multi_clk_div #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEF_DIV     (DEF_DIV),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk     (refclk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_phase  (cfg_phase),
        .cfg_commit (cfg_commit),
        .clk_en     (clk_en),
        .clk_out    (clk_out),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] out;
        logic              lck;
        logic              rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: k = cycles since the last restart, lk = cycles since lock wait began.
    int m_sh_div [NUM_CH];
    int m_sh_ph  [NUM_CH];
    int m_div    [NUM_CH];
    int m_ph     [NUM_CH];
    bit m_apply  = 1'b0;
    int m_k      = 0;
    int m_lk     = 0;
    bit last_accept = 1'b0;

    // Expected outputs for the cycle that follows the model's latest update.
    function automatic exp_t predict();
        exp_t e;
        int   d, p, j;
        e     = '0;
        e.rdy = !m_apply;
        e.lck = !m_apply && (m_lk >= LOCK_CYCLES);
        if (!m_apply && m_k > 0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                d = m_div[c];
                if (d > 0) begin
                    p = (m_ph[c] < d) ? m_ph[c] : d - 1;
                    j = m_k - 1;
                    e.en[c]  = ((j % d) == p);
                    e.out[c] = ((((j - p) % d) + d) % d) < (d / 2);
                end
            end
        end
        return e;
    endfunction

    // Model update on each rising edge from the stimulus values it drove.
    always @(posedge refclk) begin
        last_accept = 1'b0;
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_sh_div[c] = DEF_DIV; m_sh_ph[c] = 0;
                m_div[c]    = DEF_DIV; m_ph[c]    = 0;
            end
            m_apply = 1'b0; m_k = 0; m_lk = 0;
        end else if (m_apply) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c] = m_sh_div[c];
                m_ph[c]  = m_sh_ph[c];
            end
            m_apply = 1'b0; m_k = 0; m_lk = 0;
        end else begin
            if (cfg_valid) begin
                last_accept = 1'b1;
                if (int'(cfg_ch) < NUM_CH) begin
                    m_sh_div[cfg_ch] = int'(cfg_div);
                    m_sh_ph[cfg_ch]  = int'(cfg_phase);
                end
            end
            if (cfg_commit) begin
                m_apply = 1'b1;
            end else begin
                m_k = m_k + 1;
                if (m_lk < LOCK_CYCLES) m_lk = m_lk + 1;
            end
        end
        exp_q.push_back(predict());
    end

    task automatic check(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle away from the active edge.
    always @(negedge refclk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clk_en",    clk_en,                    e.en);
            check("clk_out",   clk_out,                   e.out);
            check("locked",    NUM_CH'(locked),           NUM_CH'(e.lck));
            check("cfg_ready", NUM_CH'(cfg_ready),        NUM_CH'(e.rdy));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge refclk); #1;
        end
    endtask

    task automatic do_write(input int ch, input int d, input int ph, input bit com);
        int tries = 0;
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_div    = DIV_W'(d);
        cfg_phase  = DIV_W'(ph);
        cfg_commit = com;
        forever begin
            @(posedge refclk); #1;
            cfg_commit = 1'b0;
            if (last_accept) break;
            tries++;
            if (tries > 8) begin
                checks++;
                errors++;
                $display("FAIL write_timeout at t=%0t: got no accept expected accept within 8 cycles", $time);
                break;
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        cfg_commit = 1'b1;
        @(posedge refclk); #1;
        cfg_commit = 1'b0;
    endtask

    initial begin
        int r;
        // Reset, then defaults run and lock.
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(30);
        // ch1 div=3 phase=1, commit later.
        do_write(1, 3, 1, 1'b0);
        idle(2);
        do_commit();
        idle(30);
        // ch2 div=1, ch3 disabled.
        do_write(2, 1, 0, 1'b0);
        do_write(3, 0, 0, 1'b0);
        do_commit();
        idle(30);
        // Phase beyond div clamps to div-1.
        do_write(0, 4, 7, 1'b0);
        do_commit();
        idle(20);
        // Write with same-cycle commit, a write stalled by APPLY, and an out-of-range channel.
        do_write(0, 6, 0, 1'b1);
        do_write(2, 5, 2, 1'b0);
        idle(4);
        do_write(5, 2, 0, 1'b0);
        idle(10);
        do_commit();
        idle(30);
        // Uncommitted write discarded by reset mid-lock-wait.
        do_write(1, 2, 0, 1'b0);
        do_commit();
        idle(3);
        do_write(1, 2, 0, 1'b0);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(5);
        do_commit();
        idle(30);
        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                do_write($urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 15),
                         ($urandom_range(0, 5) == 0));
            end else if (r < 5) begin
                do_commit();
            end else if (r == 5 && $urandom_range(0, 3) == 0) begin
                reset = 1'b0;
                idle($urandom_range(1, 2));
                reset = 1'b1;
            end else begin
                idle($urandom_range(1, 25));
            end
        end
        idle(2);
        @(negedge refclk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
